// File: rtl/vga_fb_arbiter.sv
// ---------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port framebuffer RAM between the VGA scanout fetcher
// (read-only) and a drawing/CPU writer (write-only). Scanout wins by
// default. An urgent scanout request always wins. A writer that has lost
// STARVE_MAX cycles in a row beats a non-urgent scanout request. Every RAM
// control output is registered.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   disp_req        scanout read request (one read per granted cycle)
//   disp_urgent     scanout line FIFO near-empty, display must win
//   disp_addr       scanout read address
//   disp_grant      display request accepted this cycle (combinational)
//   disp_valid      disp_data holds read data (3 cycles after grant)
//   disp_data       returned pixel
//   wr_req          writer request, level, held until wr_ack
//   wr_addr/wr_data write address/data, stable while wr_req is high
//   wr_ack          one-cycle pulse, write is on the RAM bus this cycle
//   wr_starved      writer wait counter has reached STARVE_MAX
//   mem_addr/mem_we/mem_wdata   registered RAM controls
//   mem_rdata       RAM read data, valid 1 cycle after a read address
// ---------------------------------------------------------------------------
module vga_fb_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 12,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic              disp_urgent,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_grant,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              wr_starved,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] STARVE_CNT = 8'(STARVE_MAX);

    typedef enum logic [1:0] {
        GNT_IDLE  = 2'd0,
        GNT_DISP  = 2'd1,
        GNT_WRITE = 2'd2
    } gnt_t;

    gnt_t       gnt;
    logic [7:0] wait_cnt;
    logic [7:0] wait_nxt;
    // rd_v1: read address on the RAM bus, rd_v2: mem_rdata valid
    logic       rd_v1;
    logic       rd_v2;

    // Per-cycle arbitration. The !wr_ack terms stop the still-high wr_req
    // in its own ack cycle from winning a second time.
    always_comb begin
        gnt = GNT_IDLE;
        if (rst) begin
            gnt = GNT_IDLE;
        end else if (disp_req && disp_urgent) begin
            gnt = GNT_DISP;
        end else if (wr_req && wr_starved && !wr_ack) begin
            gnt = GNT_WRITE;
        end else if (disp_req) begin
            gnt = GNT_DISP;
        end else if (wr_req && !wr_ack) begin
            gnt = GNT_WRITE;
        end
    end

    assign disp_grant = (gnt == GNT_DISP);

    // Wait counter holds during the ack cycle and saturates while an urgent
    // display keeps beating a starved writer.
    always_comb begin
        wait_nxt = wait_cnt;
        if (!wr_req || gnt == GNT_WRITE) begin
            wait_nxt = 8'd0;
        end else if (!wr_ack && wait_cnt != STARVE_CNT) begin
            wait_nxt = wait_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= 8'd0;
            wr_starved <= 1'b0;
        end else begin
            wait_cnt   <= wait_nxt;
            wr_starved <= (wait_nxt == STARVE_CNT);
        end
    end

    // RAM bus: address holds its last value on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wr_ack    <= 1'b0;
        end else begin
            mem_we <= (gnt == GNT_WRITE);
            wr_ack <= (gnt == GNT_WRITE);
            if (gnt == GNT_DISP) begin
                mem_addr <= disp_addr;
            end else if (gnt == GNT_WRITE) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end

    // Fixed 3-cycle read return: grant -> address -> RAM data -> disp_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_v1      <= 1'b0;
            rd_v2      <= 1'b0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            rd_v1      <= (gnt == GNT_DISP);
            rd_v2      <= rd_v1;
            disp_valid <= rd_v2;
            if (rd_v2) begin
                disp_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        disp_req = 1'b0;
    logic        disp_urgent = 1'b0;
    logic [16:0] disp_addr = '0;
    logic        disp_grant;
    logic        disp_valid;
    logic [11:0] disp_data;
    logic        wr_req = 1'b0;
    logic [16:0] wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        wr_ack;
    logic        wr_starved;
    logic [16:0] mem_addr;
    logic        mem_we;
    logic [11:0] mem_wdata;
    logic [11:0] mem_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [16:0] addr;
        logic [11:0] data;
        int          at;
    } exp_t;

    exp_t rd_q[$];
    exp_t wr_q[$];

    vga_fb_arbiter #(.ADDR_W(17), .DATA_W(12), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_urgent(disp_urgent), .disp_addr(disp_addr),
        .disp_grant(disp_grant), .disp_valid(disp_valid), .disp_data(disp_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .wr_starved(wr_starved),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous read returning addr + 0x100.
    always @(posedge clk) mem_rdata <= mem_addr[11:0] + 12'h100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [16:0] a, input logic [11:0] d, input int at);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.at   = at;
        return e;
    endfunction

    // Monitor: every RAM write and every returned pixel must match the
    // oldest outstanding expectation, on the expected cycle.
    always @(negedge clk) begin
        if (mem_we || wr_ack) begin
            if (wr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual=we%0d/ack%0d required=none (cycle %0d)",
                         mem_we, wr_ack, cyc);
            end else begin
                exp_t e;
                e = wr_q.pop_front();
                chk("wr_cycle", cyc, e.at);
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
                chk("wr_we", mem_we, 1);
                chk("wr_ack", wr_ack, 1);
            end
        end
        if (disp_valid) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_disp_valid actual=%0h required=none (cycle %0d)",
                         disp_data, cyc);
            end else begin
                exp_t e;
                e = rd_q.pop_front();
                chk("rd_cycle", cyc, e.at);
                chk("rd_data", disp_data, e.data);
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_grant", disp_grant, 0);
        chk("rst_valid", disp_valid, 0);
        chk("rst_ddata", disp_data, 0);
        chk("rst_ack", wr_ack, 0);
        chk("rst_starved", wr_starved, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_wdata", mem_wdata, 0);
        step();
        rst = 1'b0;

        // Idle for 20 cycles
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("idle_we", mem_we, 0);
            chk("idle_valid", disp_valid, 0);
            step();
        end

        // Reset while a read is in flight: it must never return
        disp_req  = 1'b1;
        disp_addr = 17'h5;
        @(negedge clk);
        chk("inflight_grant", disp_grant, 1);
        step();
        disp_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("inflight_rst_maddr", mem_addr, 0);
        step();
        step();
        rst = 1'b0;
        repeat (6) step();

        // Reset between write grant and RAM issue: no write, no ack
        wr_req  = 1'b1;
        wr_addr = 17'h77;
        wr_data = 12'h5A5;
        @(negedge clk);
        chk("midwr_grant", disp_grant, 0);
        rst = 1'b1;
        step();
        wr_req = 1'b0;
        @(negedge clk);
        chk("midwr_ack", wr_ack, 0);
        chk("midwr_we", mem_we, 0);
        step();
        rst = 1'b0;
        repeat (4) step();

        // Single write, no display
        wr_req  = 1'b1;
        wr_addr = 17'h00010;
        wr_data = 12'hABC;
        wr_q.push_back(mk(17'h00010, 12'hABC, cyc + 1));
        @(negedge clk);
        chk("single_grant", disp_grant, 0);
        step();
        @(negedge clk);
        chk("single_ack", wr_ack, 1);
        step();
        wr_req = 1'b0;
        repeat (4) step();

        // Read stream, addresses 0..4
        for (int i = 0; i < 5; i++) begin
            disp_req  = 1'b1;
            disp_addr = 17'(i);
            rd_q.push_back(mk(17'(i), 12'(12'h100 + i), cyc + 3));
            @(negedge clk);
            chk("stream_grant", disp_grant, 1);
            step();
        end
        disp_req = 1'b0;
        repeat (6) step();

        // Starvation: writer loses 8 cycles, then takes one display slot
        wr_req  = 1'b1;
        wr_addr = 17'h55;
        wr_data = 12'h123;
        for (int k = 0; k < 10; k++) begin
            disp_req  = 1'b1;
            disp_addr = 17'(32'h20 + k);
            if (k == 8) wr_q.push_back(mk(17'h55, 12'h123, cyc + 1));
            else        rd_q.push_back(mk(17'(32'h20 + k), 12'(12'h120 + k), cyc + 3));
            @(negedge clk);
            chk("starve_grant", disp_grant, (k != 8));
            chk("starve_flag", wr_starved, (k == 8));
            step();
        end
        disp_req = 1'b0;
        wr_req   = 1'b0;
        repeat (6) step();

        // Urgent override: starved writer waits until urgency drops
        wr_req  = 1'b1;
        wr_addr = 17'h66;
        wr_data = 12'h456;
        for (int k = 0; k < 14; k++) begin
            disp_req    = 1'b1;
            disp_urgent = (k < 12);
            disp_addr   = 17'(32'h40 + k);
            if (k == 12) wr_q.push_back(mk(17'h66, 12'h456, cyc + 1));
            else         rd_q.push_back(mk(17'(32'h40 + k), 12'(12'h140 + k), cyc + 3));
            @(negedge clk);
            chk("urgent_grant", disp_grant, (k != 12));
            chk("urgent_flag", wr_starved, (k >= 8 && k <= 12));
            step();
        end
        disp_req    = 1'b0;
        disp_urgent = 1'b0;
        wr_req      = 1'b0;
        repeat (6) step();

        // Alternation: display on even cycles, writes fill the odd slots
        for (int k = 0; k < 8; k++) begin
            disp_req  = (k % 2 == 0);
            disp_addr = 17'(32'h80 + k);
            wr_req    = 1'b1;
            if (k % 2 == 1 || k == 0) begin
                wr_addr = 17'(32'h200 + (k | 1));
                wr_data = 12'(12'h300 + (k | 1));
            end
            if (k % 2 == 1) wr_q.push_back(mk(17'(32'h200 + k), 12'(12'h300 + k), cyc + 1));
            else            rd_q.push_back(mk(17'(32'h80 + k), 12'(12'h180 + k), cyc + 3));
            @(negedge clk);
            chk("alt_grant", disp_grant, (k % 2 == 0));
            chk("alt_starved", wr_starved, 0);
            step();
        end
        disp_req = 1'b0;
        wr_req   = 1'b0;
        repeat (6) step();

        chk("rd_queue_empty", rd_q.size(), 0);
        chk("wr_queue_empty", wr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
